// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked sharing of one
// UART transmitter among NUM_REQ byte-stream requesters.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 256
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [NUM_REQ-1:0]   i_Req_DV,
  input  logic [8*NUM_REQ-1:0] i_Req_Byte,
  input  logic [NUM_REQ-1:0]   i_Req_Last,
  output logic [NUM_REQ-1:0]   o_Req_Ready,
  output logic [NUM_REQ-1:0]   o_Grant,
  output logic                 o_Busy,
  output logic                 o_Timeout,
  output logic                 o_TX_DV,
  output logic [7:0]           o_TX_Byte,
  input  logic                 i_TX_Active,
  input  logic                 i_TX_Done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(HOLD_TIMEOUT + 1);

  localparam logic [CW-1:0] CNT_LAST =
    CW'(HOLD_TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_LAST =
    IW'(NUM_REQ - 1);
  localparam logic [IW:0] NREQ =
    (IW+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_t;

  state_t state;
  state_t state_d;

  logic [NUM_REQ-1:0] grant_d;
  logic [IW-1:0]      idx;
  logic [IW-1:0]      idx_d;
  logic [IW-1:0]      idx_nxt;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      ptr_d;
  logic [IW-1:0]      win;
  logic [IW-1:0]      cand;
  logic [IW:0]        sum;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_d;
  logic               last;
  logic               last_d;
  logic               found;
  logic               hs;
  logic               tx_dv_d;
  logic               timeout_d;
  logic [7:0]         tx_byte_d;

  assign o_Busy  = (state != IDLE);
  assign hs      = |(o_Req_Ready & i_Req_DV);
  assign idx_nxt = (idx == IDX_LAST) ?
                   '0 : idx + IW'(1);

  // Only the owner may hand over a byte, and only
  // while the UART is not mid-frame.
  always_comb begin
    o_Req_Ready = '0;
    if (state == SEND && !i_TX_Active)
      o_Req_Ready = o_Grant;
  end

  // First requester at or after r_Ptr, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum  = {1'b0, ptr} + (IW+1)'(i);
      cand = (sum >= NREQ) ?
             IW'(sum - NREQ) : IW'(sum);
      if (!found && i_Req_DV[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d   = state;
    grant_d   = o_Grant;
    idx_d     = idx;
    ptr_d     = ptr;
    cnt_d     = '0;
    last_d    = last;
    tx_dv_d   = 1'b0;
    tx_byte_d = o_TX_Byte;
    timeout_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (found) begin
          state_d = SEND;
          grant_d = NUM_REQ'(1) << win;
          idx_d   = win;
        end
      end
      SEND: begin
        if (hs) begin
          tx_dv_d   = 1'b1;
          tx_byte_d =
            i_Req_Byte[{idx, 3'b000} +: 8];
          last_d    = i_Req_Last[idx];
          state_d   = WAIT;
        end else if (cnt == CNT_LAST) begin
          timeout_d = 1'b1;
          grant_d   = '0;
          ptr_d     = idx_nxt;
          state_d   = IDLE;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      WAIT: begin
        if (i_TX_Done) begin
          if (last) begin
            grant_d = '0;
            ptr_d   = idx_nxt;
            state_d = IDLE;
          end else begin
            state_d = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state     <= IDLE;
      o_Grant   <= '0;
      idx       <= '0;
      ptr       <= '0;
      cnt       <= '0;
      last      <= 1'b0;
      o_TX_DV   <= 1'b0;
      o_TX_Byte <= '0;
      o_Timeout <= 1'b0;
    end else begin
      state     <= state_d;
      o_Grant   <= grant_d;
      idx       <= idx_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      last      <= last_d;
      o_TX_DV   <= tx_dv_d;
      o_TX_Byte <= tx_byte_d;
      o_Timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and randomized checks of
// uart_tx_arbiter against a packet-order reference model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int HT = 16;

  logic           i_Clk       = 1'b0;
  logic           i_Rst       = 1'b1;
  logic [N-1:0]   i_Req_DV    = '0;
  logic [8*N-1:0] i_Req_Byte  = '0;
  logic [N-1:0]   i_Req_Last  = '0;
  logic           i_TX_Active = 1'b0;
  logic           i_TX_Done   = 1'b0;
  logic [N-1:0]   o_Req_Ready;
  logic [N-1:0]   o_Grant;
  logic           o_Busy;
  logic           o_Timeout;
  logic           o_TX_DV;
  logic [7:0]     o_TX_Byte;

  uart_tx_arbiter #(
    .NUM_REQ      (N),
    .HOLD_TIMEOUT (HT)
  ) dut (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Req_DV    (i_Req_DV),
    .i_Req_Byte  (i_Req_Byte),
    .i_Req_Last  (i_Req_Last),
    .o_Req_Ready (o_Req_Ready),
    .o_Grant     (o_Grant),
    .o_Busy      (o_Busy),
    .o_Timeout   (o_Timeout),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Active (i_TX_Active),
    .i_TX_Done   (i_TX_Done)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct packed {
    logic [1:0] own;
    logic [7:0] b;
  } exp_t;

  exp_t       exp_q [$];
  logic [8:0] rq_mem [N][256];
  int         rq_head [N];
  int         rq_tail [N];

  int m_ptr, fr_cnt, stall_run;
  int n_to, extra, ovl, gap_err;
  int n_chk, n_err;
  bit force_act, stall_en;
  logic [N-1:0] prev_g = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, want);
    end
  endtask

  task automatic push(input int k,
                      input logic lst,
                      input logic [7:0] b);
    rq_mem[k][rq_tail[k]] = {lst, b};
    rq_tail[k]++;
  endtask

  task automatic exp_push(input int o,
                          input logic [7:0] b);
    exp_t x;
    x.own = 2'(o);
    x.b   = b;
    exp_q.push_back(x);
  endtask

  // Packet-level round robin over the queued packets.
  task automatic plan();
    int h [N];
    int w;
    int c;
    bit lst;
    for (int k = 0; k < N; k++) h[k] = rq_head[k];
    w = 0;
    while (w >= 0) begin
      w = -1;
      for (int i = 0; i < N; i++) begin
        c = (m_ptr + i) % N;
        if (w < 0 && h[c] < rq_tail[c]) w = c;
      end
      if (w >= 0) begin
        lst = 1'b0;
        while (!lst && h[w] < rq_tail[w]) begin
          exp_push(w, rq_mem[w][h[w]][7:0]);
          lst = rq_mem[w][h[w]][8];
          h[w]++;
        end
        m_ptr = (w + 1) % N;
      end
    end
  endtask

  // One clock: drive requesters, clock, model the UART.
  task automatic cycle();
    logic [N-1:0] hs;
    logic [8:0]   e;
    bit           held;
    exp_t         x;
    held = 1'b0;
    for (int k = 0; k < N; k++) begin
      i_Req_DV[k] = 1'b0;
      if (rq_head[k] < rq_tail[k]) begin
        e = rq_mem[k][rq_head[k]];
        if (stall_en && o_Grant[k] &&
            stall_run < 3 &&
            $urandom_range(0, 3) == 0) begin
          held = 1'b1;
        end else begin
          i_Req_DV[k]         = 1'b1;
          i_Req_Byte[8*k +: 8] = e[7:0];
          i_Req_Last[k]       = e[8];
        end
      end
    end
    stall_run = held ? stall_run + 1 : 0;
    #1;
    hs = o_Req_Ready & i_Req_DV;
    @(posedge i_Clk);
    #1;
    for (int k = 0; k < N; k++)
      if (hs[k]) rq_head[k]++;
    i_TX_Done = 1'b0;
    if (fr_cnt > 0) begin
      fr_cnt--;
      if (fr_cnt == 0) i_TX_Done = 1'b1;
    end
    if (o_TX_DV) begin
      if (fr_cnt > 0) ovl++;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("tx_byte", 32'(o_TX_Byte), 32'(x.b));
        chk("tx_owner", 32'(o_Grant),
            32'(1) << x.own);
      end else begin
        extra++;
      end
      fr_cnt = $urandom_range(3, 10);
    end
    i_TX_Active = (fr_cnt > 0) || force_act;
    if (o_Timeout) n_to++;
    if ($countones(o_Grant) > 1 ||
        (prev_g != 0 && o_Grant != 0 &&
         o_Grant != prev_g))
      gap_err++;
    prev_g = o_Grant;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || o_Busy ||
            fr_cnt != 0) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 0);
    chk("drain_busy", 32'(o_Busy), 0);
  endtask

  task automatic do_reset();
    i_Rst = 1'b1;
    cycle();
    cycle();
    chk("rst_grant", 32'(o_Grant), 0);
    chk("rst_busy", 32'(o_Busy), 0);
    chk("rst_tmo", 32'(o_Timeout), 0);
    chk("rst_txdv", 32'(o_TX_DV), 0);
    chk("rst_txbyte", 32'(o_TX_Byte), 0);
    chk("rst_ready", 32'(o_Req_Ready), 0);
    i_Rst = 1'b0;
    m_ptr = 0;
  endtask

  initial begin
    int n;
    int np;
    int len;
    do_reset();

    // single byte, latency, release, next search
    push(1, 1'b1, 8'h3A);
    plan();
    cycle();
    chk("t1_grant", 32'(o_Grant), 32'h2);
    chk("t1_busy", 32'(o_Busy), 1);
    chk("t1_ready", 32'(o_Req_Ready), 32'h2);
    chk("t1_dv_early", 32'(o_TX_DV), 0);
    cycle();
    chk("t1_dv", 32'(o_TX_DV), 1);
    n = 0;
    while (!i_TX_Done && n < 40) begin
      cycle();
      n++;
    end
    chk("t1_done_seen", 32'(i_TX_Done), 1);
    cycle();
    chk("t1_rel_grant", 32'(o_Grant), 0);
    chk("t1_rel_busy", 32'(o_Busy), 0);
    push(0, 1'b1, 8'h55);
    push(3, 1'b1, 8'h66);
    plan();
    cycle();
    chk("t1_rr_next", 32'(o_Grant), 32'h8);
    drain(400);

    // strict rotation between two requesters
    do_reset();
    push(0, 1'b1, 8'h11);
    push(2, 1'b1, 8'h22);
    push(0, 1'b1, 8'h11);
    push(2, 1'b1, 8'h22);
    plan();
    drain(800);

    // multi-byte packet holds the grant
    push(3, 1'b0, 8'hA1);
    push(3, 1'b0, 8'hA2);
    push(3, 1'b1, 8'hA3);
    push(0, 1'b1, 8'h55);
    plan();
    drain(800);

    // UART busy blocks the handshake
    force_act   = 1'b1;
    i_TX_Active = 1'b1;
    push(1, 1'b1, 8'h77);
    plan();
    cycle();
    chk("t5_grant", 32'(o_Grant), 32'h2);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t5_ready", 32'(o_Req_Ready), 0);
      chk("t5_nodv", 32'(o_TX_DV), 0);
    end
    force_act   = 1'b0;
    i_TX_Active = (fr_cnt > 0);
    cycle();
    chk("t5_launch", 32'(o_TX_DV), 1);
    drain(400);

    // stalled owner is revoked by timeout
    do_reset();
    n_to = 0;
    push(1, 1'b0, 8'hC0);
    push(2, 1'b1, 8'h99);
    exp_push(1, 8'hC0);
    exp_push(2, 8'h99);
    n = 0;
    while (!i_TX_Done && n < 60) begin
      cycle();
      n++;
    end
    chk("t4_done_seen", 32'(i_TX_Done), 1);
    cycle();
    chk("t4_resend", 32'(o_Grant), 32'h2);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!o_Timeout && n < 40);
    chk("t4_tmo_lat", 32'(n), 32'(HT));
    chk("t4_revoked", 32'(o_Grant), 0);
    cycle();
    chk("t4_tmo_pulse", 32'(o_Timeout), 0);
    chk("t4_next", 32'(o_Grant), 32'h4);
    drain(400);
    chk("t4_tmo_count", 32'(n_to), 1);

    // reset while waiting on a frame
    push(1, 1'b1, 8'h44);
    exp_push(1, 8'h44);
    n = 0;
    while (!o_TX_DV && n < 10) begin
      cycle();
      n++;
    end
    chk("t6_launch", 32'(o_TX_DV), 1);
    push(0, 1'b1, 8'h88);
    i_Rst = 1'b1;
    cycle();
    chk("t6_grant", 32'(o_Grant), 0);
    chk("t6_busy", 32'(o_Busy), 0);
    chk("t6_txdv", 32'(o_TX_DV), 0);
    chk("t6_txbyte", 32'(o_TX_Byte), 0);
    chk("t6_ready", 32'(o_Req_Ready), 0);
    chk("t6_tmo", 32'(o_Timeout), 0);
    i_Rst = 1'b0;
    m_ptr = 0;
    exp_push(0, 8'h88);
    cycle();
    chk("t6_regrant", 32'(o_Grant), 32'h1);
    chk("t6_blocked", 32'(o_Req_Ready), 0);
    drain(400);

    // randomized packets with owner stalls
    do_reset();
    stall_en = 1'b1;
    n_to     = 0;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < N; k++) begin
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++)
            push(k, b == len - 1, 8'($urandom));
        end
      end
      plan();
      drain(3000);
    end
    stall_en = 1'b0;
    chk("rand_tmo", 32'(n_to), 0);
    chk("extra_launch", 32'(extra), 0);
    chk("tx_overlap", 32'(ovl), 0);
    chk("grant_gap", 32'(gap_err), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
